// File: rtl/system_acl_iface_sys_desc_pkg.sv
// Shared definitions for the system description reader: FSM encoding, default sizes
// and the byteenable constant. Optional checksum output: SYS_DESC_READER_CHECKSUM_EN.
package system_acl_iface_sys_desc_pkg;

    localparam int SYS_DESC_ADDR_W     = 9;
    localparam int SYS_DESC_DATA_W     = 64;
    localparam int SYS_DESC_FIFO_DEPTH = 4;

    // Wide enough for any sane DATA_W; the top slices off DATA_W/8 bits.
    localparam logic [127:0] SYS_DESC_BE_ALL_ONES = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/system_acl_iface_sys_desc_reader_fifo.sv
// Synchronous output buffer: read data comes straight from the registered read
// pointer; a write into a full FIFO is accepted only alongside a read.
module system_acl_iface_sys_desc_reader_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = 1;
    localparam logic [AW:0]   CNT_ONE   = 1;
    localparam logic [AW:0]   CNT_DEPTH = DEPTH;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              wr_fire;
    logic              rd_fire;

    assign full    = (count_q == CNT_DEPTH);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign rd_fire = rd_en && !empty;
    assign wr_fire = wr_en && (!full || rd_en);

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_fire) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (rd_fire) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (wr_fire && !rd_fire)      count_q <= count_q + CNT_ONE;
            else if (rd_fire && !wr_fire) count_q <= count_q - CNT_ONE;
        end
    end

endmodule

// File: rtl/system_acl_iface_sys_description_reader.sv
// Burst reader for the system description ROM over Avalon-MM, streaming words out
// through a credit-limited FIFO. Optional checksum port: SYS_DESC_READER_CHECKSUM_EN.
module system_acl_iface_sys_description_reader
    import system_acl_iface_sys_desc_pkg::*;
#(
    parameter int ADDR_W     = SYS_DESC_ADDR_W,
    parameter int DATA_W     = SYS_DESC_DATA_W,
    parameter int FIFO_DEPTH = SYS_DESC_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       word_count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_read,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    input  logic                  avm_waitrequest,
    input  logic [DATA_W-1:0]     avm_readdata,
    input  logic                  avm_readdatavalid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_last,
    output logic [1:0]            dbg_state_o
`ifdef SYS_DESC_READER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]     checksum
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   WC_ONE   = 1;
    localparam logic [CW-1:0]     PEND_ONE = 1;
    localparam logic [CW:0]       CREDITS  = FIFO_DEPTH;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     issue_rem_q, issue_rem_d;
    logic [ADDR_W:0]     out_rem_q, out_rem_d;
    logic [CW-1:0]       pending_q, pending_d;
    logic                zero_done_q, zero_done_d;

    logic [CW-1:0]       fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic [DATA_W-1:0]   fifo_rd_data;
    logic [CW:0]         credit_used;
    logic                start_acc;
    logic                req_acc;
    logic                rdv_in;
    logic                out_fire;
    logic                last_fire;

    assign busy        = (state_q != ST_IDLE) || zero_done_q;
    assign start_acc   = start && !busy;
    // Reads in flight plus buffered words never exceed the FIFO, so returns always fit.
    assign credit_used = {1'b0, pending_q} + {1'b0, fifo_count};
    assign avm_read    = (state_q == ST_ISSUE) && !fifo_full && (credit_used < CREDITS);
    assign req_acc     = avm_read && !avm_waitrequest;
    assign rdv_in      = avm_readdatavalid && (state_q != ST_IDLE);

    assign out_valid   = !fifo_empty;
    assign out_fire    = out_valid && out_ready;
    assign out_last    = out_valid && (out_rem_q == WC_ONE);
    assign last_fire   = out_fire && out_last;
    assign out_data    = fifo_empty ? '0 : fifo_rd_data;
    assign done        = zero_done_q || ((state_q == ST_DRAIN) && last_fire);

    assign avm_address    = addr_q;
    assign avm_byteenable = SYS_DESC_BE_ALL_ONES[DATA_W/8-1:0];
    assign dbg_state_o    = state_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        issue_rem_d = issue_rem_q;
        out_rem_d   = out_rem_q;
        pending_d   = pending_q;
        zero_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    addr_d      = base_addr;
                    issue_rem_d = word_count;
                    out_rem_d   = word_count;
                    if (word_count == '0) zero_done_d = 1'b1;
                    else                  state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (req_acc) begin
                    addr_d      = addr_q + ADDR_ONE;
                    issue_rem_d = issue_rem_q - WC_ONE;
                    if (issue_rem_q == WC_ONE) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_fire) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (out_fire) out_rem_d = out_rem_q - WC_ONE;
        if (req_acc && !rdv_in) begin
            pending_d = pending_q + PEND_ONE;
        end else if (!req_acc && rdv_in && (pending_q != '0)) begin
            pending_d = pending_q - PEND_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            issue_rem_q <= '0;
            out_rem_q   <= '0;
            pending_q   <= '0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            issue_rem_q <= issue_rem_d;
            out_rem_q   <= out_rem_d;
            pending_q   <= pending_d;
            zero_done_q <= zero_done_d;
        end
    end

    system_acl_iface_sys_desc_reader_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rdv_in),
        .wr_data (avm_readdata),
        .rd_en   (out_fire),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifdef SYS_DESC_READER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    always_ff @(posedge clk) begin
        if (reset || start_acc) checksum_q <= '0;
        else if (out_fire)      checksum_q <= checksum_q ^ out_data;
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_system_acl_iface_sys_description_reader.sv
// Self-checking bench: random-latency ROM slave model, output scoreboard and
// per-scenario tasks. Build with SYS_DESC_READER_CHECKSUM_EN to cover the checksum.
`timescale 1ns/1ps
module tb_system_acl_iface_sys_description_reader;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 4;
    localparam int NWORDS = 512;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [ADDR_W-1:0]   base_addr;
    logic [ADDR_W:0]     word_count;
    logic                busy, done, avm_read, avm_waitrequest, avm_readdatavalid;
    logic                out_valid, out_ready, out_last;
    logic [ADDR_W-1:0]   avm_address;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic [DATA_W-1:0]   avm_readdata, out_data;
    logic [1:0]          dbg_state;
`ifdef SYS_DESC_READER_CHECKSUM_EN
    logic [DATA_W-1:0]   checksum;
`endif

    always #5 clk = ~clk;

    system_acl_iface_sys_description_reader dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .base_addr         (base_addr),
        .word_count        (word_count),
        .busy              (busy),
        .done              (done),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_last          (out_last),
        .dbg_state_o       (dbg_state)
`ifdef SYS_DESC_READER_CHECKSUM_EN
        ,
        .checksum          (checksum)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] rom [NWORDS];
    logic [DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [DATA_W-1:0] sl_data_q[$];
    longint            sl_due_q[$];
    longint            cyc = 0;
    longint            last_due = 0;

    int  lat_min = 2, lat_max = 2, wr_pct = 0;
    bit  ready_rand = 0, ready_low = 0, zero_mode = 0;
    int  inflight = 0, done_cnt = 0, acc_total = 0;
    logic [DATA_W-1:0] csum_model = '0;

    bit                prev_stall = 0, prev_ostall = 0;
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] prev_odata;
    logic              prev_olast;

    // Slave + monitor: drive this cycle's inputs, settle, then score the handshakes
    // that the coming posedge will commit (skipped when reset is high at that edge).
    always @(negedge clk) begin
        bit                fire_last;
        longint            due;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        cyc++;
        avm_waitrequest = ($urandom_range(99, 0) < wr_pct);
        if (sl_due_q.size() != 0 && sl_due_q[0] <= cyc) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = sl_data_q.pop_front();
            void'(sl_due_q.pop_front());
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = {$urandom, $urandom};
        end
        out_ready = ready_low ? 1'b0 : (ready_rand ? 1'($urandom_range(1, 0)) : 1'b1);
        #1;
        fire_last = 0;
        if (reset) begin
            prev_stall  = 0;
            prev_ostall = 0;
            inflight    = 0;
        end else begin
            if (prev_stall) begin
                n_checks++;
                if (avm_read !== 1'b1 || avm_address !== prev_addr) begin
                    n_fail++;
                    $display("FAIL stall_hold: read=%b addr=%0d, required read=1 addr=%0d", avm_read, avm_address, prev_addr);
                end
            end
            if (prev_ostall) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== prev_odata || out_last !== prev_olast) begin
                    n_fail++;
                    $display("FAIL out_hold: valid=%b data=%h last=%b, required 1 %h %b", out_valid, out_data, out_last, prev_odata, prev_olast);
                end
            end
            if (avm_read === 1'b1 && !avm_waitrequest) begin
                acc_total++;
                inflight++;
                n_checks++;
                if (exp_addr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_read: addr=%0d, required no read", avm_address);
                end else begin
                    ea = exp_addr_q.pop_front();
                    if (avm_address !== ea) begin
                        n_fail++;
                        $display("FAIL read_addr: got %0d, required %0d", avm_address, ea);
                    end
                end
                due = cyc + longint'($urandom_range(lat_max, lat_min));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                sl_data_q.push_back(rom[avm_address]);
                sl_due_q.push_back(due);
            end
            if (out_valid === 1'b1 && out_ready) begin
                inflight--;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: data=%h, required no output", out_data);
                end else begin
                    ed = exp_q.pop_front();
                    fire_last = (exp_q.size() == 0);
                    csum_model ^= ed;
                    if (out_data !== ed || out_last !== fire_last) begin
                        n_fail++;
                        $display("FAIL out_word: data=%h last=%b, required %h %b", out_data, out_last, ed, fire_last);
                    end
                end
            end
            if (!zero_mode) begin
                n_checks++;
                if (done !== fire_last) begin
                    n_fail++;
                    $display("FAIL done_timing: done=%b, required %b", done, fire_last);
                end
            end
            n_checks++;
            if (inflight > DEPTH) begin
                n_fail++;
                $display("FAIL credit: in flight %0d, required <= %0d", inflight, DEPTH);
            end
            if (done === 1'b1) done_cnt++;
            prev_stall  = (avm_read === 1'b1) && avm_waitrequest;
            prev_addr   = avm_address;
            prev_ostall = (out_valid === 1'b1) && !out_ready;
            prev_odata  = out_data;
            prev_olast  = out_last;
        end
    end

    task automatic load_burst(input int base, input int cnt);
        logic [ADDR_W-1:0] a;
        exp_q.delete();
        exp_addr_q.delete();
        for (int i = 0; i < cnt; i++) begin
            a = ADDR_W'((base + i) % NWORDS);
            exp_addr_q.push_back(a);
            exp_q.push_back(rom[a]);
        end
        csum_model = '0;
        done_cnt   = 0;
    endtask

    task automatic run_burst(input int base, input int cnt, input bit poke, input int budget);
        int waited;
        load_burst(base, cnt);
        @(negedge clk);
        start      = 1'b1;
        base_addr  = ADDR_W'(base);
        word_count = (ADDR_W+1)'(cnt);
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_rise: got %b, required 1", busy);
        end
        if (poke) begin
            @(negedge clk);
            start      = 1'b1;
            base_addr  = ADDR_W'(200);
            word_count = (ADDR_W+1)'(3);
            @(negedge clk);
            start = 1'b0;
        end
        waited = 0;
        while (done_cnt == 0 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        n_checks++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL done_count: got %0d pulses, required 1 (base %0d cnt %0d)", done_cnt, base, cnt);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_fall: got %b, required 0", busy);
        end
        n_checks++;
        if (exp_q.size() != 0 || exp_addr_q.size() != 0) begin
            n_fail++;
            $display("FAIL burst_complete: %0d words and %0d reads left, required 0 0", exp_q.size(), exp_addr_q.size());
        end
`ifdef SYS_DESC_READER_CHECKSUM_EN
        n_checks++;
        if (checksum !== csum_model) begin
            n_fail++;
            $display("FAIL checksum: got %h, required %h", checksum, csum_model);
        end
`endif
    endtask

    task automatic check_idle_outputs(input string tag);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || avm_read !== 1'b0 || avm_address !== '0 ||
            out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 || avm_byteenable !== '1) begin
            n_fail++;
            $display("FAIL %s: busy=%b done=%b rd=%b addr=%0d ov=%b od=%h ol=%b be=%h, required all 0 and be=ff",
                     tag, busy, done, avm_read, avm_address, out_valid, out_data, out_last, avm_byteenable);
        end
`ifdef SYS_DESC_READER_CHECKSUM_EN
        n_checks++;
        if (checksum !== '0) begin
            n_fail++;
            $display("FAIL %s_checksum: got %h, required 0", tag, checksum);
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_state");
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_reset");
    endtask

    task automatic test_basic();
        lat_min = 2; lat_max = 2; wr_pct = 0; ready_rand = 0;
        run_burst(0, 4, 0, 100);
    endtask

    task automatic test_wrap();
        run_burst(510, 4, 0, 100);
    endtask

    task automatic test_backpressure();
        ready_low = 1;
        fork
            begin
                repeat (20) @(negedge clk);
                n_checks++;
                if (done_cnt != 0 || inflight != DEPTH) begin
                    n_fail++;
                    $display("FAIL backpressure: done=%0d inflight=%0d, required 0 and %0d", done_cnt, inflight, DEPTH);
                end
                ready_low = 0;
            end
        join_none
        run_burst(40, 16, 0, 300);
    endtask

    task automatic test_random();
        lat_min = 1; lat_max = 5; wr_pct = 50; ready_rand = 1;
        run_burst(0, 512, 0, 20000);
        run_burst($urandom_range(511, 0), $urandom_range(40, 1), 1, 2000);
        lat_min = 2; lat_max = 2; wr_pct = 0; ready_rand = 0;
    endtask

    task automatic test_zero();
        int acc0;
        load_burst(0, 0);
        zero_mode = 1;
        acc0 = acc_total;
        @(negedge clk);
        start      = 1'b1;
        base_addr  = ADDR_W'(7);
        word_count = '0;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_done: got %b, required 1", done);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_after: done=%b busy=%b, required 0 0", done, busy);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (acc_total != acc0) begin
            n_fail++;
            $display("FAIL zero_no_read: %0d reads, required 0", acc_total - acc0);
        end
        zero_mode = 0;
        run_burst(300, 6, 1, 200);
    endtask

    task automatic test_reset_mid();
        int waited;
        lat_min = 5; lat_max = 5; wr_pct = 0; ready_low = 1;
        load_burst(60, 16);
        @(negedge clk);
        start      = 1'b1;
        base_addr  = ADDR_W'(60);
        word_count = (ADDR_W+1)'(16);
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (sl_due_q.size() < 3 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (sl_due_q.size() < 3) begin
            n_fail++;
            $display("FAIL mid_pending: %0d reads pending, required 3", sl_due_q.size());
        end
        done_cnt = 0;
        reset = 1'b1;
        exp_q.delete();
        exp_addr_q.delete();
        repeat (2) @(negedge clk);
        check_idle_outputs("mid_reset");
        reset     = 1'b0;
        ready_low = 0;
        waited = 0;
        while (sl_due_q.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
            n_checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL stray_rdv: out_valid=%b busy=%b, required 0 0", out_valid, busy);
            end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (done_cnt != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: done pulses %0d out_valid %b, required 0 0", done_cnt, out_valid);
        end
        lat_min = 1; lat_max = 3;
        run_burst(100, 5, 0, 200);
    endtask

    initial begin
        reset             = 1'b1;
        start             = 1'b0;
        base_addr         = '0;
        word_count        = '0;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        out_ready         = 1'b1;
        for (int i = 0; i < NWORDS; i++) rom[i] = {$urandom, $urandom};
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero();
        test_random();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
